// File: rtl/time2bin.sv
// time2bin: converts a m:ss.cc BCD preset into a binary centisecond count,
// one digit per clock by shift-and-add multiply-accumulate.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset
//   start    in   1  conversion request, sampled only when idle
//   min_in   in   4  minutes digit, 0..MAX_MIN
//   sec_tens in   4  seconds tens digit, 0..5
//   sec_ones in   4  seconds units digit, 0..9
//   cs_tens  in   4  centiseconds tens digit, 0..9
//   cs_ones  in   4  centiseconds units digit, 0..9
//   bin      out 16  result in centiseconds, updated on success only
//   busy     out  1  conversion in progress
//   done     out  1  one-cycle completion / rejection pulse
//   err      out  1  last request had an illegal digit
module time2bin #(
  parameter int unsigned MAX_MIN = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  min_in,
  input  logic [3:0]  sec_tens,
  input  logic [3:0]  sec_ones,
  input  logic [3:0]  cs_tens,
  input  logic [3:0]  cs_ones,
  output logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] MaxMin = 4'(MAX_MIN);

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  st_q, st_d;
  logic [3:0]  so_q, so_d;
  logic [3:0]  ct_q, ct_d;
  logic [3:0]  co_q, co_d;
  logic [15:0] bin_q, bin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        legal;
  logic [3:0]  dig;
  logic [15:0] x6;
  logic [15:0] x10;
  logic [15:0] mac;

  // Digit legality of the request presented on the inputs.
  assign legal = (min_in <= MaxMin)
              && (sec_tens <= 4'd5)
              && (sec_ones <= 4'd9)
              && (cs_tens <= 4'd9)
              && (cs_ones <= 4'd9);

  // Radix of the first step is 6 (tens of seconds), the rest are 10.
  assign x6  = (acc_q << 2) + (acc_q << 1);
  assign x10 = (acc_q << 3) + (acc_q << 1);

  always_comb begin
    dig = 4'd0;
    unique case (step_q)
      2'd0: dig = st_q;
      2'd1: dig = so_q;
      2'd2: dig = ct_q;
      2'd3: dig = co_q;
      default: dig = 4'd0;
    endcase
  end

  assign mac = ((step_q == 2'd0) ? x6 : x10) + {12'd0, dig};

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    st_d    = st_q;
    so_d    = so_q;
    ct_d    = ct_q;
    co_d    = co_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          st_d = sec_tens;
          so_d = sec_ones;
          ct_d = cs_tens;
          co_d = cs_ones;
          if (legal) begin
            acc_d   = {12'd0, min_in};
            step_d  = 2'd0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        acc_d  = mac;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          bin_d   = mac;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      acc_q   <= 16'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      ct_q    <= 4'd0;
      co_q    <= 4'd0;
      bin_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      st_q    <= st_d;
      so_q    <= so_d;
      ct_q    <= ct_d;
      co_q    <= co_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_time2bin.sv
// tb_time2bin: scoreboard bench for time2bin, default build and a
// MAX_MIN=5 build driven from shared digit inputs.
module tb_time2bin;

  typedef struct {
    logic [15:0] bin;
    logic        err;
    int          bc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [3:0]  mi, st, so, ct, co;
  logic [15:0] bin0, bin1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic        err0, err1;

  int checks = 0;
  int errors = 0;
  int bc0 = 0;
  int bc1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  time2bin u0 (
    .clk(clk), .rst(rst), .start(start0),
    .min_in(mi), .sec_tens(st), .sec_ones(so),
    .cs_tens(ct), .cs_ones(co),
    .bin(bin0), .busy(busy0), .done(done0), .err(err0)
  );

  time2bin #(.MAX_MIN(5)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .min_in(mi), .sec_tens(st), .sec_ones(so),
    .cs_tens(ct), .cs_ones(co),
    .bin(bin1), .busy(busy1), .done(done1), .err(err1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mon(input string nm, input logic bsy, input logic dn,
                     input logic [15:0] b, input logic e,
                     inout int bc, inout exp_t q[$]);
    exp_t x;
    if (bsy && dn) begin
      checks++;
      errors++;
      $display("FAIL %s busy_and_done: both high", nm);
    end
    if (rst) bc = 0;
    else if (bsy) bc++;
    if (dn) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s unexpected_done: got bin %0d, expected none",
                 nm, b);
      end else begin
        x = q.pop_front();
        chk({nm, " bin"}, 32'(b), 32'(x.bin));
        chk({nm, " err"}, 32'(e), 32'(x.err));
        chk({nm, " busy_cycles"}, 32'(bc), 32'(x.bc));
      end
      bc = 0;
    end
  endtask

  // Monitor samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    mon("dut9", busy0, done0, bin0, err0, bc0, q0);
    mon("dut5", busy1, done1, bin1, err1, bc1, q1);
  end

  task automatic set_dig(input logic [3:0] m, a, b, c, d);
    mi = m; st = a; so = b; ct = c; co = d;
  endtask

  task automatic wait_done(input bit s);
    int n = 0;
    while (!(s ? done1 : done0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL done_timeout: got no done, expected within 20");
    end
    @(negedge clk);
  endtask

  task automatic push(input bit s, input logic [15:0] eb,
                      input logic ee);
    exp_t x;
    x.bin = eb;
    x.err = ee;
    x.bc  = ee ? 0 : 4;
    if (s) q1.push_back(x);
    else q0.push_back(x);
  endtask

  task automatic go(input bit s, input logic [3:0] m, a, b, c, d,
                    input logic [15:0] eb, input logic ee);
    set_dig(m, a, b, c, d);
    if (s) start1 = 1'b1;
    else start0 = 1'b1;
    push(s, eb, ee);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    set_dig(4'hF, 4'hE, 4'hD, 4'hC, 4'hB);
    wait_done(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    set_dig(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset bin", 32'(bin0), 0);
    chk("reset busy", 32'(busy0), 0);
    chk("reset done", 32'(done0), 0);
    chk("reset err", 32'(err0), 0);
    chk("reset bin5", 32'(bin1), 0);
    @(negedge clk);

    go(0, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9, 16'd59999, 1'b0);
    go(0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0);
    go(0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'd8345, 1'b0);
    go(0, 4'd1, 4'd6, 4'd0, 4'd0, 4'd0, 16'd8345, 1'b1);
    chk("err held", 32'(err0), 1);
    chk("bin held", 32'(bin0), 8345);

    // rst and start on the same edge: rst wins.
    set_dig(4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
    rst = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    chk("rst+start busy", 32'(busy0), 0);
    chk("rst+start err", 32'(err0), 0);
    chk("rst+start bin", 32'(bin0), 0);
    repeat (8) @(negedge clk);

    // Second start during CALC is ignored.
    set_dig(4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
    start0 = 1'b1;
    push(0, 16'd12000, 1'b0);
    @(negedge clk);
    start0 = 1'b0;
    set_dig(4'd9, 4'd5, 4'd9, 4'd9, 4'd9);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0);
    repeat (8) @(negedge clk);
    chk("ignored start bin", 32'(bin0), 12000);

    // Reset at edge k+2 aborts a 5:30.00 conversion.
    set_dig(4'd5, 4'd3, 4'd0, 4'd0, 4'd0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort bin", 32'(bin0), 0);
    chk("abort busy", 32'(busy0), 0);
    chk("abort done", 32'(done0), 0);
    chk("abort err", 32'(err0), 0);
    repeat (8) @(negedge clk);
    go(0, 4'd5, 4'd3, 4'd0, 4'd0, 4'd0, 16'd33000, 1'b0);

    go(1, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0, 1'b1);
    chk("max5 err", 32'(err1), 1);
    go(1, 4'd5, 4'd5, 4'd9, 4'd9, 4'd9, 16'd35999, 1'b0);
    chk("max5 err cleared", 32'(err1), 0);

    repeat (8) @(negedge clk);
    chk("q0 drained", 32'(q0.size()), 0);
    chk("q1 drained", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
